// File: rtl/toggle_event_decoder.sv
// -----------------------------------------------------------------------------
// toggle_event_decoder
//
// Receive side of a toggle-handshake link. A sender in another clock domain
// flips tog_in once per event. This block brings that level into clk with a
// flop chain and turns each level change into one queued event. Events are
// handed to local logic over a valid/ready handshake. Every accepted event is
// acknowledged by flipping ack_tog back toward the sender.
//
// Parameters
//   SYNC_STAGES  synchronizer depth on tog_in (legal 2..4, default 2)
//   CNT_W        pending-counter width; capacity is 2^CNT_W-1 events
//
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   tog_in     in   asynchronous toggle level from the sender
//   evt_valid  out  at least one event pending
//   evt_ready  in   consumer accepts one event this cycle
//   ack_tog    out  flips once per accepted event
//   pending    out  number of queued events (CNT_W bits)
//   overflow   out  sticky: an event arrived while the queue was full
//   total_cnt  out  16-bit count of accepted events (wraps)
//
// Optional build macro
//   TOG_DEC_GLITCH_FILTER_EN  adds one register after the synchronizer. A
//                             level is used only once it has been stable for
//                             two consecutive cycles, so a one-cycle pulse is
//                             rejected. Latency and the start-up (INIT)
//                             period each grow by one cycle.
// -----------------------------------------------------------------------------
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tog_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             ack_tog,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic [15:0]      total_cnt
);

    // Start-up period: long enough for the reset-time zeros to flush out of
    // the synchronizer (and the filter stage, if present). During this time
    // the edge detector is re-primed instead of producing events.
`ifdef TOG_DEC_GLITCH_FILTER_EN
    localparam int INIT_LEN = SYNC_STAGES + 2;
`else
    localparam int INIT_LEN = SYNC_STAGES + 1;
`endif

    localparam int               PRIME_W    = 3;
    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(INIT_LEN - 1);
    localparam logic [CNT_W-1:0] PEND_MAX   = '1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // -------------------------------------------------------------------------
    // Synchronizer chain
    // -------------------------------------------------------------------------
    logic sync_reg [SYNC_STAGES];
    logic s_last;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) begin
                        sync_reg[gi] <= 1'b0;
                    end else begin
                        sync_reg[gi] <= tog_in;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (reset) begin
                        sync_reg[gi] <= 1'b0;
                    end else begin
                        sync_reg[gi] <= sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign s_last = sync_reg[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Optional glitch filter: the synchronized level counts only when it
    // matches its value one cycle earlier.
    // -------------------------------------------------------------------------
    logic level_ok;

`ifdef TOG_DEC_GLITCH_FILTER_EN
    logic s_filt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_filt_reg <= 1'b0;
        end else begin
            s_filt_reg <= s_last;
        end
    end

    assign level_ok = (s_last == s_filt_reg);
`else
    assign level_ok = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Edge detect and handshake terms
    // -------------------------------------------------------------------------
    state_t             state_reg;
    logic [PRIME_W-1:0] prime_reg;
    logic               tog_prev_reg;
    logic [CNT_W-1:0]   pending_reg;
    logic               ack_tog_reg;
    logic               overflow_reg;
    logic [15:0]        total_cnt_reg;

    logic edge_det;
    logic evt_arrive;
    logic transfer;

    assign edge_det   = level_ok && (s_last ^ tog_prev_reg);
    // Edges seen while priming are artefacts of reset, not real events.
    assign evt_arrive = (state_reg == ST_RUN) && edge_det;
    // Valid comes only from the registered counter, never from the edge.
    assign evt_valid  = (pending_reg != '0);
    assign transfer   = evt_valid && evt_ready;

    // -------------------------------------------------------------------------
    // Control state machine and event bookkeeping
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_INIT;
            prime_reg     <= '0;
            tog_prev_reg  <= 1'b0;
            pending_reg   <= '0;
            ack_tog_reg   <= 1'b0;
            overflow_reg  <= 1'b0;
            total_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    // Follow the raw level so the first RUN cycle sees no
                    // difference, whatever level the sender was parked at.
                    tog_prev_reg <= s_last;
                    if (prime_reg == PRIME_LAST) begin
                        state_reg <= ST_RUN;
                    end else begin
                        prime_reg <= prime_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (level_ok) begin
                        tog_prev_reg <= s_last;
                    end
                end
                default: begin
                    state_reg <= ST_INIT;
                    prime_reg <= '0;
                end
            endcase

            // Arrival and departure in the same cycle cancel in the count;
            // a full queue can still take an event if one leaves that cycle.
            if (evt_arrive && !transfer) begin
                if (pending_reg == PEND_MAX) begin
                    overflow_reg <= 1'b1;
                end else begin
                    pending_reg <= pending_reg + 1'b1;
                end
            end else if (!evt_arrive && transfer) begin
                pending_reg <= pending_reg - 1'b1;
            end

            if (transfer) begin
                ack_tog_reg   <= ~ack_tog_reg;
                total_cnt_reg <= total_cnt_reg + 16'd1;
            end
        end
    end

    assign pending   = pending_reg;
    assign ack_tog   = ack_tog_reg;
    assign overflow  = overflow_reg;
    assign total_cnt = total_cnt_reg;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_toggle_event_decoder
//
// Self-checking bench for toggle_event_decoder at default parameters. Each
// toggle the bench sends is pushed to a scoreboard queue if the queue model
// has room; each handshake transfer pops one entry and advances the expected
// ack_tog / total_cnt. Inputs change and outputs are sampled on the falling
// edge. Define TOG_DEC_GLITCH_FILTER_EN for both files to exercise the filter.
// -----------------------------------------------------------------------------
module tb_toggle_event_decoder;

`ifdef TOG_DEC_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int CAP = 15;

    logic        clk;
    logic        reset;
    logic        tog_in;
    logic        evt_valid;
    logic        evt_ready;
    logic        ack_tog;
    logic [3:0]  pending;
    logic        overflow;
    logic [15:0] total_cnt;

    int          n_checks;
    int          n_errors;
    int          sb_q [$];
    int          seq_num;
    int          model_total;
    logic        model_ack;
    logic        model_ovf;

    toggle_event_decoder #(
        .SYNC_STAGES(2),
        .CNT_W      (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tog_in   (tog_in),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .ack_tog  (ack_tog),
        .pending  (pending),
        .overflow (overflow),
        .total_cnt(total_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle. A transfer decided by the current inputs pops the
    // scoreboard; after the edge the handshake outputs are compared.
    task automatic tick();
        if (!reset && evt_valid && evt_ready) begin
            check_val("sb_has_entry", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                void'(sb_q.pop_front());
            end
            model_total = (model_total + 1) % 65536;
            model_ack   = ~model_ack;
        end
        @(posedge clk);
        @(negedge clk);
        if (reset) begin
            sb_q.delete();
            model_total = 0;
            model_ack   = 1'b0;
            model_ovf   = 1'b0;
        end else begin
            check_val("ack_tog", ack_tog, model_ack);
            check_val("total_cnt", total_cnt, model_total);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Flip tog_in and record the event the queue model expects to keep.
    task automatic send_toggle();
        tog_in = ~tog_in;
        if (sb_q.size() < CAP) begin
            seq_num++;
            sb_q.push_back(seq_num);
        end else begin
            model_ovf = 1'b1;
        end
        $display("toggle sent: tog_in=%0d queued=%0d", tog_in, sb_q.size());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        check_val("rst_pending", pending, 0);
        check_val("rst_valid", evt_valid, 0);
        check_val("rst_ack", ack_tog, 0);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_total", total_cnt, 0);
        reset = 1'b0;
        ticks(6);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        seq_num     = 0;
        model_total = 0;
        model_ack   = 1'b0;
        model_ovf   = 1'b0;
        reset       = 1'b1;
        tog_in      = 1'b0;
        evt_ready   = 1'b0;
        @(negedge clk);

        // --- single event: exact latency, no ack yet -------------------------
        do_reset();
        send_toggle();
        ticks(LAT - 1);
        check_val("lat_not_early", pending, 0);
        tick();
        check_val("lat_pending", pending, 1);
        check_val("lat_valid", evt_valid, 1);
        check_val("lat_ack", ack_tog, 0);

        // --- one-cycle ready pulse consumes it -------------------------------
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check_val("pop_pending", pending, 0);
        check_val("pop_ack", ack_tog, 1);
        check_val("pop_total", total_cnt, 1);
        check_val("pop_valid", evt_valid, 0);
        $display("transfer: total_cnt=%0d ack_tog=%0d", total_cnt, ack_tog);

        // --- streaming with ready held high ---------------------------------
        do_reset();
        evt_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send_toggle();
            for (int k = 0; k < 4; k++) begin
                tick();
                check_val("stream_pend_le1", (pending <= 4'd1), 1);
            end
        end
        ticks(LAT + 2);
        evt_ready = 1'b0;
        check_val("stream_total", total_cnt, 20);
        check_val("stream_ack", ack_tog, 0);
        check_val("stream_ovf", overflow, 0);
        check_val("stream_sb_empty", sb_q.size(), 0);
        $display("stream done: total_cnt=%0d", total_cnt);

        // --- saturation and overflow ----------------------------------------
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send_toggle();
            ticks(4);
            check_val("fill_pending", pending, sb_q.size());
            check_val("fill_ovf", overflow, model_ovf);
        end
        check_val("sat_pending", pending, CAP);
        check_val("sat_ovf", overflow, 1);
        evt_ready = 1'b1;
        ticks(15);
        evt_ready = 1'b0;
        check_val("drain_total", total_cnt, 15);
        check_val("drain_pending", pending, 0);
        check_val("drain_valid", evt_valid, 0);
        check_val("drain_ovf_sticky", overflow, 1);
        ticks(2);
        check_val("drain_total_hold", total_cnt, 15);

        // --- tog_in high through reset: no phantom event --------------------
        tog_in = 1'b1;
        do_reset();
        ticks(6);
        check_val("prime_pending", pending, 0);
        check_val("prime_valid", evt_valid, 0);
        for (int i = 0; i < 4; i++) begin
            send_toggle();
            ticks(4);
        end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check_val("pre_rst_pending", pending, 3);
        check_val("pre_rst_ack", ack_tog, 1);

        // --- mid-operation reset --------------------------------------------
        reset = 1'b1;
        tick();
        check_val("midrst_pending", pending, 0);
        check_val("midrst_valid", evt_valid, 0);
        check_val("midrst_ack", ack_tog, 0);
        check_val("midrst_ovf", overflow, 0);
        check_val("midrst_total", total_cnt, 0);
        reset = 1'b0;
        ticks(6);
        check_val("post_rst_pending", pending, 0);

`ifdef TOG_DEC_GLITCH_FILTER_EN
        // --- glitch rejection then clean toggle -----------------------------
        tog_in = ~tog_in;
        tick();
        tog_in = ~tog_in;
        ticks(8);
        check_val("glitch_ignored", pending, 0);
        send_toggle();
        ticks(LAT - 1);
        check_val("filt_not_early", pending, 0);
        tick();
        check_val("filt_lat_pending", pending, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/toggle_event_decoder.md
# toggle_event_decoder

Receive end of the toggle-handshake link. Takes a level signal that a T flip-flop in another clock domain flips once per event, and synchronizes it into `clk`. Each detected transition becomes one queued event, delivered to local logic over a valid/ready handshake. Every consumed event is acknowledged by flipping `ack_tog` back toward the sender, which closes the handshake loop.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops on `tog_in`; legal range 2..4.
- `CNT_W`, default 4: width of the pending-event counter; capacity is 2^CNT_W-1 events.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `tog_in`  in  1  asynchronous toggle level from the sender.
- `evt_valid`  out  1  at least one event pending.
- `evt_ready`  in  1  consumer accepts one event.
- `ack_tog`  out  1  flips once per accepted event.
- `pending`  out  CNT_W  number of queued events.
- `overflow`  out  1  sticky; an event was dropped.
- `total_cnt`  out  16  accepted-event count, wraps.

## Operation
- Synchronizer: chain `s[0..SYNC_STAGES-1]`, with `s[0] <= tog_in`. `s_last` is the final stage.
- Edge detect: `tog_prev <= s_last` every cycle. `edge = s_last ^ tog_prev` is combinational.
- State machine INIT/RUN:
  - Reset enters INIT with a priming counter at 0.
  - INIT lasts exactly SYNC_STAGES+1 cycles after reset deasserts, then moves to RUN.
  - In INIT, `tog_prev` tracks `s_last` and `edge` is ignored, so a tog_in level of 1 at reset release generates no event.
- `evt_valid = (pending != 0)`; it is driven from the registered counter only.
- A transfer occurs at any edge where `evt_valid && evt_ready`. A transfer:
  - decrements `pending`,
  - flips `ack_tog`,
  - increments `total_cnt` modulo 2^16.
- Per-cycle `pending` update in RUN:
  - edge only: +1.
  - transfer only: −1.
  - edge and transfer together: unchanged; `ack_tog` still flips and `total_cnt` still increments.
  - neither: hold.
- Full: `pending` = 2^CNT_W−1 with an edge and no simultaneous transfer. The event is dropped, `pending` holds and `overflow` sets. Full with edge and transfer together is not an overflow.
- `overflow` clears only on reset.
- `evt_ready` while `evt_valid` = 0 has no effect.

## Timing
- Reset values: `pending` 0, `evt_valid` 0, `ack_tog` 0, `overflow` 0, `total_cnt` 0, sync chain 0, `tog_prev` 0, state INIT.
- Reset is synchronous and has priority over all other updates. Reset asserted mid-operation discards queued events and does not flip `ack_tog`.
- Latency: suppose `tog_in` changes and is captured at edge E1. Then `pending` increments at edge E(SYNC_STAGES+1), and `evt_valid` is high in the following cycle. Default latency is 3 edges.
- `ack_tog` and `total_cnt` update on the transfer edge itself.
- The sender must hold each level at least SYNC_STAGES+1 `clk` cycles. Faster toggling may merge events; this is not detected.

## Configuration
- `TOG_DEC_GLITCH_FILTER_EN` defined:
  - An extra register `s_filt` follows `s_last`.
  - A level is accepted only when `s_last == s_filt`.
  - `tog_prev` updates only on accepted levels, and `edge` uses the accepted level.
  - Latency grows by one cycle (4 edges at default).
  - The INIT length becomes SYNC_STAGES+2 cycles.
  - A one-cycle pulse on `s_last` produces no event.
- Undefined: no filter; behaviour and latency are as given above.

## Test plan
- Reset, wait 3 cycles, flip `tog_in` once with `evt_ready`=0. Required: `pending`=1 and `evt_valid`=1 exactly 3 edges after capture; `ack_tog` stays 0.
- From that state, pulse `evt_ready` for one cycle. Required: `pending`=0, `ack_tog`=1, `total_cnt`=1, `evt_valid` low the next cycle.
- Hold `evt_ready`=1 and flip `tog_in` every 4 cycles, 20 times. Required: `total_cnt`=20, `ack_tog`=0, `pending` never above 1, `overflow`=0.
- Hold `evt_ready`=0 and send 17 toggles at default CNT_W=4. Required: `pending` saturates at 15, `overflow`=1 after the 16th toggle, then drain 15 transfers gives `total_cnt`=15.
- Hold `tog_in`=1 through reset and release it. Required: no event, `pending` stays 0. Then assert reset while `pending`=3: all outputs return to their reset values on the next edge.
- With `TOG_DEC_GLITCH_FILTER_EN`: force a one-cycle pulse on `s_last`, then a clean toggle. Required: the pulse is ignored, and the toggle appears in `pending` 4 edges after capture.
